// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, frame constants and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam int FRAME_BITS = 10;
    localparam int ACK_EDGE   = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// rtl/ps2_edge_sync.sv - 3-flop synchroniser for ps2_clk/ps2_data plus clock falling-edge pulse
module ps2_edge_sync (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    logic [2:0] clk_sr;
    logic [2:0] data_sr;

    // Idle PS/2 lines float high, so the chains reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sr  <= '1;
            data_sr <= '1;
        end else begin
            clk_sr  <= {clk_sr[1:0], ps2_clk};
            data_sr <= {data_sr[1:0], ps2_data};
        end
    end

    assign clk_sync  = clk_sr[2];
    assign data_sync = data_sr[2];
    assign fall      = clk_sr[2] & ~clk_sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with inhibit, shift and ACK check
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err_nack,
    output logic       err_timeout
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    IDX_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0]    IDX_ACK  = 4'(ACK_EDGE - 1);

    ps2_state_t            state;
    logic [CW-1:0]         cnt;
    logic [3:0]            idx;
    logic [FRAME_BITS-1:0] frame;
    logic                  clk_sync;
    logic                  data_sync;
    logic                  fall;
    logic                  timed_out;

    ps2_edge_sync u_sync (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .fall      (fall)
    );

    assign timed_out = (cnt == TO_LAST);
    assign tx_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            frame       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        frame       <= {1'b1, odd_parity(tx_data), tx_data};
                        cnt         <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt         <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REQ: begin
                    if (cnt == REQ_LAST) begin
                        cnt        <= '0;
                        idx        <= '0;
                        ps2_clk_oe <= 1'b0;
                        state      <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // From here on the device owns the clock; timeout beats a same-cycle fall.
                SHIFT: begin
                    if (timed_out) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (fall) begin
                        cnt         <= '0;
                        ps2_data_oe <= ~frame[idx];
                        idx         <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= ACK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (timed_out) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (fall && idx == IDX_ACK) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                        if (data_sync) begin
                            err_nack <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (timed_out) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (clk_sync && data_sync) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= fall ? '0 : cnt + 1'b1;
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int H = 60;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err_nack;
    logic       err_timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_nack   = 0;
    int n_tmo    = 0;
    int n_acc    = 0;
    int n_multi  = 0;

    logic [7:0]  vec_d [4] = '{8'hED, 8'h00, 8'h01, 8'hFF};
    logic [10:0] vec_f [4] = '{11'b1_1_11101101_0, 11'b1_1_00000000_0,
                               11'b1_0_00000001_0, 11'b1_1_11111111_0};

    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (5000),
        .REQ_CYCLES     (50),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err_nack    (err_nack),
        .err_timeout (err_timeout)
    );

    always @(posedge clk) begin
        if (done)        n_done++;
        if (err_nack)    n_nack++;
        if (err_timeout) n_tmo++;
        if (int'(done) + int'(err_nack) + int'(err_timeout) > 1) n_multi++;
        if (clrn && tx_valid && tx_ready) n_acc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: measures inhibit/request, then clocks the frame and samples on rising edges.
    task automatic dev_frame(input logic ackb, input int stop_at,
                             output logic [10:0] bits, output int inh, output int req);
        int w;
        bits = '0;
        inh  = 0;
        req  = 0;
        w    = 0;
        while (!ps2_clk_oe && w < 20000) begin @(negedge clk); w++; end
        while (ps2_clk_oe && !ps2_data_oe && inh < 20000) begin inh++; @(negedge clk); end
        while (ps2_clk_oe && ps2_data_oe && req < 20000) begin req++; @(negedge clk); end
        bits[0] = ps2_data;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data = ackb;
            cycles(H);
            dev_clk = 1'b0;
            cycles(H);
            if (k == stop_at) return;
            dev_clk = 1'b1;
            if (k <= 10) begin
                bits[k] = ps2_data;
            end else begin
                cycles(5);
                dev_data = 1'b1;
            end
        end
    endtask

    initial begin
        logic [10:0] bits;
        int inh, req, w, n, d0, k0, t0, a0;

        cycles(3);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_pulses", {done, err_nack, err_timeout}, 0);
        clrn = 1'b1;
        cycles(3);

        for (int i = 0; i < 4; i++) begin
            d0 = n_done;
            send(vec_d[i]);
            check("busy_after_accept", busy, 1);
            dev_frame(1'b0, 0, bits, inh, req);
            cycles(10);
            check("inhibit_cycles", inh, 5000);
            check("req_cycles", req, 50);
            check("frame_bits", bits, vec_f[i]);
            check("done_count", n_done - d0, 1);
            check("ready_after", tx_ready, 1);
        end

        d0 = n_done;
        k0 = n_nack;
        send(8'hF3);
        dev_frame(1'b1, 0, bits, inh, req);
        cycles(10);
        check("nack_frame", bits, 11'b1_1_11110011_0);
        check("nack_count", n_nack - k0, 1);
        check("nack_no_done", n_done - d0, 0);
        check("nack_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("nack_ready", tx_ready, 1);

        d0 = n_done;
        t0 = n_tmo;
        send(8'h12);
        w = 0;
        while (ps2_clk_oe && w < 20000) begin @(negedge clk); w++; end
        n = 0;
        while (!err_timeout && n < 5000) begin @(negedge clk); n++; end
        check("timeout_latency", n, 2000);
        check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        cycles(3);
        check("timeout_count", n_tmo - t0, 1);
        check("timeout_no_done", n_done - d0, 0);
        check("timeout_ready", tx_ready, 1);

        d0 = n_done;
        a0 = n_acc;
        send(8'hED);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        dev_frame(1'b0, 0, bits, inh, req);
        check("busy_first_frame", bits, 11'b1_1_11101101_0);
        w = 0;
        while (!done && w < 200) begin @(negedge clk); w++; end
        check("busy_done_seen", done, 1);
        check("busy_no_early_accept", n_acc - a0, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        dev_frame(1'b0, 0, bits, inh, req);
        cycles(10);
        check("busy_second_frame", bits, 11'b1_0_11110100_0);
        check("busy_second_inhibit", inh, 5000);
        check("busy_done_count", n_done - d0, 2);
        check("busy_accept_count", n_acc - a0, 2);

        d0 = n_done;
        k0 = n_nack;
        t0 = n_tmo;
        send(8'h00);
        dev_frame(1'b0, 4, bits, inh, req);
        check("pre_reset_data_oe", ps2_data_oe, 1);
        #2;
        clrn = 1'b0;
        #1;
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        check("reset_tx_ready", tx_ready, 1);
        dev_clk = 1'b1;
        cycles(3);
        clrn = 1'b1;
        cycles(5);
        check("reset_no_pulses", (n_done - d0) + (n_nack - k0) + (n_tmo - t0), 0);
        send(8'hFF);
        dev_frame(1'b0, 0, bits, inh, req);
        cycles(10);
        check("post_reset_frame", bits, 11'b1_1_11111111_0);
        check("post_reset_done", n_done - d0, 1);

        check("pulses_exclusive", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
